alu_operand_sequencer: RTL

Front-end controller that feeds the 4-bit ALU from a nibble-wide valid/ready stream and returns its 8-bit result over a second valid/ready stream. Each transaction captures an opcode and operand A on the first accepted nibble and operand B on the second. It then holds both operands and the function code stable on the ALU inputs, registers the ALU's combinational result, and offers that result downstream. It sits between a producer of nibbles (sequencer, UART unpacker, test harness) and the combinational ALU, which it drives as the initiator.

---
 rtl/alu_operand_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// ============================================================================
// alu_operand_sequencer : collects opcode/A/B nibbles, drives the 4-bit ALU,
// and returns the registered 8-bit result over a valid/ready stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_operand_sequencer (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] din,
   input  logic [1:0] din_op,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_function,
   input  logic [7:0] alu_result,
   output logic [7:0] result,
   output logic       result_valid,
   input  logic       result_ready,
   output logic [7:0] ops_done
);

   localparam logic [1:0] S_LOAD_A = 2'd0;
   localparam logic [1:0] S_LOAD_B = 2'd1;
   localparam logic [1:0] S_EXEC   = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   logic [1:0] r_state;
   logic [1:0] w_next_state;

   logic       w_din_ready;
   logic       w_accept_a;
   logic       w_accept_b;
   logic       w_exec;
   logic       w_handshake;

   logic [3:0] r_alu_a;
   logic [3:0] r_alu_b;
   logic [1:0] r_alu_function;
   logic [7:0] r_result;
   logic       r_result_valid;
   logic [7:0] r_ops_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_LOAD_A;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_LOAD_A: if (din_valid)    w_next_state = S_LOAD_B;
         S_LOAD_B: if (din_valid)    w_next_state = S_EXEC;
         S_EXEC:                     w_next_state = S_HOLD;
         S_HOLD:   if (result_ready) w_next_state = S_LOAD_A;
         default:                    w_next_state = S_LOAD_A;
      endcase
   end

   // Ready is a pure function of state so din_valid never reaches din_ready.
   always_comb begin
      w_din_ready = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
      w_accept_a  = (r_state == S_LOAD_A) && din_valid;
      w_accept_b  = (r_state == S_LOAD_B) && din_valid;
      w_exec      = (r_state == S_EXEC);
      w_handshake = (r_state == S_HOLD) && result_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_alu_a        <= 4'h0;
         r_alu_b        <= 4'h0;
         r_alu_function <= 2'd0;
         r_result       <= 8'h00;
         r_result_valid <= 1'b0;
         r_ops_done     <= 8'h00;
      end else begin
         if (w_accept_a) begin
            r_alu_a        <= din;
            r_alu_function <= din_op;
         end
         if (w_accept_b) begin
            r_alu_b <= din;
         end
         if (w_exec) begin
            r_result       <= alu_result;
            r_result_valid <= 1'b1;
            r_ops_done     <= r_ops_done + 8'd1;
         end else if (w_handshake) begin
            r_result_valid <= 1'b0;
         end
      end
   end

   assign din_ready    = w_din_ready;
   assign alu_a        = r_alu_a;
   assign alu_b        = r_alu_b;
   assign alu_function = r_alu_function;
   assign result       = r_result;
   assign result_valid = r_result_valid;
   assign ops_done     = r_ops_done;

endmodule

`default_nettype wire
